// File: rtl/hqm_aw_rrwrand_sched_ctl.sv
// Scheduling controller for the two-stage RR / weighted-random arbiter: holds the
// per-priority RR index, masks requests by credit and backpressure, registers grants.
module hqm_aw_rrwrand_sched_ctl #(
    parameter int NUM_REQS   = 8,
    parameter int NUM_PRI    = 8,
    parameter int CRED_W     = 4,
    parameter int NUM_REQSB2 = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    parameter int NUM_PRIB2  = (NUM_PRI > 1) ? $clog2(NUM_PRI) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [CRED_W-1:0]               cfg_cred_limit,
    input  logic [NUM_PRI*NUM_REQS-1:0]     raw_reqs,
    output logic [NUM_PRI*NUM_REQS-1:0]     arb_reqs,
    output logic [NUM_PRI*NUM_REQSB2-1:0]   index_f,
    input  logic                            arb_winner_v,
    input  logic [NUM_PRIB2-1:0]            arb_winner_pri,
    input  logic [NUM_REQSB2-1:0]           arb_winner,
    output logic                            sched_v,
    output logic [NUM_PRIB2-1:0]            sched_pri,
    output logic [NUM_REQSB2-1:0]           sched_req,
    input  logic                            sched_ready,
    input  logic                            cred_ret_v,
    input  logic [NUM_REQSB2-1:0]           cred_ret_req,
    output logic                            err_cred,
    output logic                            busy
);

    // Output handshake: a grant transfers on any cycle with sched_v && sched_ready;
    // while sched_v is high and sched_ready low, sched_v/pri/req are held stable.
    logic [CRED_W-1:0]     cnt [NUM_REQS];
    logic [NUM_REQSB2-1:0] idx [NUM_PRI];

    logic                  accept;
    logic                  grant;
    logic                  err_next;
    logic [NUM_REQS-1:0]   eligible;
    logic [NUM_REQS-1:0]   cnt_nz;
    logic [NUM_REQS-1:0]   grant_hit;
    logic [NUM_REQS-1:0]   ret_hit;
    logic [NUM_PRI-1:0]    pri_hit;

    assign accept = !sched_v || sched_ready;
    assign grant  = arb_winner_v && accept;

    always_comb begin
        eligible  = '0;
        cnt_nz    = '0;
        grant_hit = '0;
        ret_hit   = '0;
        pri_hit   = '0;
        for (int r = 0; r < NUM_REQS; r++) begin
            eligible[r]  = cnt[r] < cfg_cred_limit;
            cnt_nz[r]    = |cnt[r];
            grant_hit[r] = grant && (arb_winner == NUM_REQSB2'(r));
            ret_hit[r]   = cred_ret_v && (cred_ret_req == NUM_REQSB2'(r));
        end
        for (int p = 0; p < NUM_PRI; p++) begin
            pri_hit[p] = grant && (arb_winner_pri == NUM_PRIB2'(p));
        end
        // An out-of-range requestor matches no ret_hit bit and therefore errors;
        // a same-cycle grant covers a return even when the counter is zero.
        err_next = cred_ret_v && !(|(ret_hit & (cnt_nz | grant_hit)));
    end

    always_comb begin
        arb_reqs = '0;
        index_f  = '0;
        for (int p = 0; p < NUM_PRI; p++) begin
            arb_reqs[p*NUM_REQS +: NUM_REQS] =
                raw_reqs[p*NUM_REQS +: NUM_REQS] & eligible & {NUM_REQS{accept}};
            index_f[p*NUM_REQSB2 +: NUM_REQSB2] = idx[p];
        end
    end

    assign busy = sched_v || (|cnt_nz);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sched_v   <= 1'b0;
            sched_pri <= '0;
            sched_req <= '0;
            err_cred  <= 1'b0;
        end else begin
            err_cred <= err_next;
            if (grant) begin
                sched_v   <= 1'b1;
                sched_pri <= arb_winner_pri;
                sched_req <= arb_winner;
            end else if (sched_ready) begin
                sched_v   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REQS; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REQS; r++) begin
                if (ret_hit[r] && !grant_hit[r] && cnt_nz[r]) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end else if (grant_hit[r] && !ret_hit[r]) begin
                    cnt[r] <= cnt[r] + 1'b1;
                end
            end
        end
    end

    // Reset to the last requestor so the first RR search starts at requestor 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PRI; p++) idx[p] <= NUM_REQSB2'(NUM_REQS - 1);
        end else begin
            for (int p = 0; p < NUM_PRI; p++) begin
                if (pri_hit[p]) idx[p] <= arb_winner;
            end
        end
    end

endmodule

// File: tb/tb_hqm_aw_rrwrand_sched_ctl.sv
// Bench for hqm_aw_rrwrand_sched_ctl: bench-side arbiter plus a credit/grant model,
// directed scenarios with literal expectations, then a randomized run.
module tb_hqm_aw_rrwrand_sched_ctl;
    localparam int NR = 8;
    localparam int NP = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  cfg_cred_limit;
    logic [63:0] raw_reqs;
    logic [63:0] arb_reqs;
    logic [23:0] index_f;
    logic        arb_winner_v;
    logic [2:0]  arb_winner_pri;
    logic [2:0]  arb_winner;
    logic        sched_v;
    logic [2:0]  sched_pri;
    logic [2:0]  sched_req;
    logic        sched_ready;
    logic        cred_ret_v;
    logic [2:0]  cred_ret_req;
    logic        err_cred;
    logic        busy;

    always #5 clk = ~clk;

    hqm_aw_rrwrand_sched_ctl dut (
        .clk(clk), .rst_n(rst_n), .cfg_cred_limit(cfg_cred_limit),
        .raw_reqs(raw_reqs), .arb_reqs(arb_reqs), .index_f(index_f),
        .arb_winner_v(arb_winner_v), .arb_winner_pri(arb_winner_pri),
        .arb_winner(arb_winner), .sched_v(sched_v), .sched_pri(sched_pri),
        .sched_req(sched_req), .sched_ready(sched_ready), .cred_ret_v(cred_ret_v),
        .cred_ret_req(cred_ret_req), .err_cred(err_cred), .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    // Reference state: outstanding credits per requestor, last winner per priority.
    int exp_cnt [NR];
    int exp_idx [NP];
    bit exp_v;
    bit exp_err;
    int exp_pri;
    int exp_req;
    logic [63:0] seen_arb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) exp_cnt[r] = 0;
        for (int p = 0; p < NP; p++) exp_idx[p] = NR - 1;
        exp_v = 0; exp_err = 0; exp_pri = 0; exp_req = 0;
    endtask

    function automatic logic [63:0] model_arb_reqs();
        logic [63:0] m = '0;
        bit acc = !exp_v || sched_ready;
        for (int p = 0; p < NP; p++)
            for (int r = 0; r < NR; r++)
                m[p*NR+r] = raw_reqs[p*NR+r] && (exp_cnt[r] < int'(cfg_cred_limit)) && acc;
        return m;
    endfunction

    function automatic logic [23:0] model_index_f();
        logic [23:0] v = '0;
        for (int p = 0; p < NP; p++) v[p*3 +: 3] = exp_idx[p][2:0];
        return v;
    endfunction

    function automatic bit model_busy();
        bit b = exp_v;
        for (int r = 0; r < NR; r++) if (exp_cnt[r] > 0) b = 1;
        return b;
    endfunction

    task automatic compare_outputs();
        check("sched_v", 64'(sched_v), 64'(exp_v));
        check("sched_pri", 64'(sched_pri), 64'(exp_pri));
        check("sched_req", 64'(sched_req), 64'(exp_req));
        check("err_cred", 64'(err_cred), 64'(exp_err));
        check("busy", 64'(busy), 64'(model_busy()));
        check("index_f", 64'(index_f), 64'(model_index_f()));
        check("arb_reqs", arb_reqs, model_arb_reqs());
    endtask

    task automatic model_update();
        bit acc;
        bit g;
        bit err_next;
        bool_same: begin end
        acc = !exp_v || sched_ready;
        g = arb_winner_v && acc;
        err_next = 0;
        if (cred_ret_v) begin
            if (g && arb_winner == cred_ret_req) begin
            end else if (exp_cnt[cred_ret_req] > 0) begin
                exp_cnt[cred_ret_req]--;
            end else begin
                err_next = 1;
            end
        end
        if (g) begin
            if (!(cred_ret_v && cred_ret_req == arb_winner)) exp_cnt[arb_winner]++;
            exp_idx[arb_winner_pri] = arb_winner;
            exp_v = 1;
            exp_pri = arb_winner_pri;
            exp_req = arb_winner;
        end else if (exp_v && sched_ready) begin
            exp_v = 0;
        end
        exp_err = err_next;
    endtask

    // One cycle: starts and ends 1 time unit after a rising edge.
    task automatic step(input logic [63:0] raw, input bit rdy, input bit rv, input int rr);
        logic [63:0] areq;
        int plist [$];
        int p;
        raw_reqs = raw;
        sched_ready = rdy;
        cred_ret_v = rv;
        cred_ret_req = rr[2:0];
        arb_winner_v = 0;
        #1;
        compare_outputs();
        seen_arb = arb_reqs;
        areq = model_arb_reqs();
        if (areq != 0) begin
            for (int q = 0; q < NP; q++) if (areq[q*NR +: NR] != 0) plist.push_back(q);
            p = plist[$urandom_range(0, plist.size() - 1)];
            arb_winner_pri = p[2:0];
            for (int k = 1; k <= NR; k++) begin
                int r = (exp_idx[p] + k) % NR;
                if (areq[p*NR+r] && !arb_winner_v) begin
                    arb_winner = r[2:0];
                    arb_winner_v = 1;
                end
            end
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        arb_winner_v = 0;
        raw_reqs = '0;
        cred_ret_v = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    int seq [6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        rst_n = 0;
        cfg_cred_limit = 4'd2;
        raw_reqs = '0;
        arb_winner_v = 0; arb_winner_pri = 0; arb_winner = 0;
        sched_ready = 1; cred_ret_v = 0; cred_ret_req = 0;
        #2;
        do_reset();
        check("reset_sched_v", 64'(sched_v), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_err", 64'(err_cred), 64'd0);
        check("reset_index_f", 64'(index_f), 64'hFFFFFF);

        // Credit limit of two on (p0,r0).
        step(64'h1, 1, 0, 0);
        check("lim_arb1", seen_arb, 64'h1);
        step(64'h1, 1, 0, 0);
        check("lim_arb2", seen_arb, 64'h1);
        check("lim_v", 64'(sched_v), 64'd1);
        check("lim_req", 64'(sched_req), 64'd0);
        step(64'h1, 1, 0, 0);
        check("lim_blocked", seen_arb, 64'h0);
        step(64'h1, 1, 1, 0);
        check("lim_blocked_ret", seen_arb, 64'h0);
        step(64'h1, 1, 0, 0);
        check("lim_after_ret", seen_arb, 64'h1);
        check("lim_regrant", 64'(sched_v), 64'd1);

        // Round robin r0,r1,r2 at priority 3.
        cfg_cred_limit = 4'd15;
        for (int i = 0; i < 6; i++) begin
            step(64'h7 << 24, 1, 0, 0);
            check("rr_req", 64'(sched_req), 64'(seq[i]));
            check("rr_index3", 64'(index_f[11:9]), 64'(seq[i]));
        end

        // Backpressure holds the grant and suppresses requests.
        for (int i = 0; i < 5; i++) begin
            step(64'h7 << 24, 0, 0, 0);
            check("stall_arb", seen_arb, 64'h0);
        end
        check("stall_v", 64'(sched_v), 64'd1);
        check("stall_req", 64'(sched_req), 64'd2);
        step(64'h7 << 24, 1, 0, 0);
        check("stall_release_req", 64'(sched_req), 64'd0);

        // Same-cycle grant and return on r5, then underflow.
        do_reset();
        step(64'h1 << 5, 1, 0, 0);
        step(64'h1 << 5, 1, 1, 5);
        check("same_cyc_err", 64'(err_cred), 64'd0);
        check("same_cyc_req", 64'(sched_req), 64'd5);
        step(64'h0, 1, 1, 5);
        check("ret_ok_err", 64'(err_cred), 64'd0);
        step(64'h0, 1, 1, 5);
        check("underflow_err", 64'(err_cred), 64'd1);
        step(64'h0, 1, 0, 0);
        check("err_pulse_end", 64'(err_cred), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);

        // Lowering the limit below the outstanding count.
        do_reset();
        cfg_cred_limit = 4'd4;
        for (int i = 0; i < 3; i++) step(64'h4, 1, 0, 0);
        cfg_cred_limit = 4'd1;
        for (int i = 0; i < 3; i++) begin
            step(64'h4, 1, 1, 2);
            check("lowered_blocked", seen_arb, 64'h0);
            check("lowered_no_err", 64'(err_cred), 64'd0);
        end
        step(64'h4, 1, 0, 0);
        check("lowered_unblocked", seen_arb, 64'h4);

        // Asynchronous reset with a grant in flight.
        cfg_cred_limit = 4'd15;
        step(64'h1, 0, 0, 0);
        rst_n = 0;
        #1;
        check("async_sched_v", 64'(sched_v), 64'd0);
        check("async_busy", 64'(busy), 64'd0);
        check("async_index_f", 64'(index_f), 64'hFFFFFF);
        do_reset();
        step(64'h30, 1, 0, 0);
        check("post_reset_req", 64'(sched_req), 64'd4);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if (i % 200 == 0) cfg_cred_limit = 4'($urandom_range(0, 6));
            if (i == 777) do_reset();
            step({$urandom, $urandom} & {$urandom, $urandom},
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, NR - 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/hqm_aw_rrwrand_sched_ctl.md
# hqm_AW_rrwrand_sched_ctl

Scheduling controller for the two-stage round-robin / weighted-random arbiter with externally held RR index. It owns the per-priority RR index state and masks requests by per-requestor credit availability and downstream backpressure. It registers each grant into a valid/ready output stage and tracks outstanding grants until credit return. The arbiter sits combinationally between `arb_reqs`/`index_f` (out) and `arb_winner_*` (in).

## Interface
- NUM_REQS, 8, requestors per priority
- NUM_PRI, 8, priority levels
- CRED_W, 4, credit counter width
- NUM_REQSB2, AW_logb2(NUM_REQS-1)+1, requestor index width
- NUM_PRIB2, AW_logb2(NUM_PRI-1)+1, priority index width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_cred_limit  in  CRED_W  max outstanding grants per requestor; 0 blocks all
- raw_reqs  in  NUM_PRI*NUM_REQS  requests; bit p*NUM_REQS+r = requestor r at priority p
- arb_reqs  out  NUM_PRI*NUM_REQS  masked requests to arbiter
- index_f  out  NUM_PRI*NUM_REQSB2  per-priority last-winner index to arbiter
- arb_winner_v  in  1  arbiter selected a winner this cycle
- arb_winner_pri  in  NUM_PRIB2  winning priority
- arb_winner  in  NUM_REQSB2  winning requestor
- sched_v  out  1  registered grant valid
- sched_pri  out  NUM_PRIB2  registered grant priority
- sched_req  out  NUM_REQSB2  registered grant requestor
- sched_ready  in  1  downstream accepts grant
- cred_ret_v  in  1  credit return strobe
- cred_ret_req  in  NUM_REQSB2  requestor returning one credit
- err_cred  out  1  registered one-cycle pulse on illegal credit return
- busy  out  1  sched_v or any credit counter nonzero

## Operation
- accept = !sched_v | sched_ready.
- eligible[r] = (cnt[r] < cfg_cred_limit).
- arb_reqs[p*NUM_REQS+r] = raw_reqs[same] & eligible[r] & accept. No requests are presented while the output stage is stalled, so the arbiter's weight/LFSR state advances only on real grants.
- On arb_winner_v (only possible when accept):
  - load sched_v=1, sched_pri=arb_winner_pri, sched_req=arb_winner;
  - index_f[arb_winner_pri] <= arb_winner;
  - cnt[arb_winner] += 1.
- Other index_f slices hold. RR search at priority p starts at index_f[p]+1 with wrap.
- sched_v && sched_ready && !arb_winner_v: sched_v <= 0; pri/req hold last value.
- sched_v && !sched_ready: sched_v/pri/req stable; arb_reqs all zero.
- Credit return, cred_ret_v=1:
  - cred_ret_req < NUM_REQS and cnt>0: cnt -= 1.
  - cnt==0 or cred_ret_req >= NUM_REQS: no counter change; err_cred=1 next cycle.
- Same-cycle grant and return to the same requestor: net count unchanged, no error, even when cnt==0.
- Counters never exceed cfg_cred_limit through grants. If cfg_cred_limit is lowered below cnt, the requestor stays blocked until returns bring cnt below the limit; no error.
- Priority/weight selection is owned entirely by the arbiter; this block never overrides its winner.

## Timing
- Reset values:
  - sched_v=0, sched_pri=0, sched_req=0, err_cred=0, busy=0;
  - all cnt=0;
  - every index_f slice = NUM_REQS-1, so requestor 0 wins first.
- arb_reqs is combinational from raw_reqs, cnt, sched_v and sched_ready. There is a combinational sched_ready -> arb_reqs path.
- Grant latency: arb_winner_v at cycle N -> sched_v=1 at N+1.
- Throughput is 1 grant/cycle with sched_ready held high and credits available.
- cnt and index_f update at the edge after the grant. The new eligibility and RR position apply from cycle N+1.
- Credit return at cycle N: the requestor becomes eligible at N+1.
- busy is registered-state derived with no added latency: busy = sched_v | (|cnt).
- Asynchronous reset mid-operation: all state returns to reset values immediately. An in-flight sched_v is dropped and outstanding credits are forgotten.

## Test plan
- cfg_cred_limit=2; raw_reqs bit 0 (p0,r0) held; sched_ready=1 -> two grants (p0,r0) on consecutive cycles, then arb_reqs=0 and cnt[0]=2. Return r0 once -> one more grant one cycle later.
- Requestors r0, r1, r2 at p3; limit=15; sched_ready=1 -> sched_req sequence 0,1,2,0,1,2, and index_f[3] tracks each winner.
- Grant pending; sched_ready=0 for 5 cycles -> sched_v/pri/req stable, arb_reqs=0, arbiter winner_v=0. sched_ready=1 -> next grant on the following cycle.
- cnt[5]=1; same cycle: grant r5 and cred_ret_req=5 -> cnt[5] stays 1, err_cred=0. Return r5 twice -> cnt=0, then err_cred pulses 1 cycle.
- cred_ret_req=NUM_REQS (out of range), cnt=0 -> err_cred pulse. Lower cfg_cred_limit from 4 to 1 with cnt[2]=3 -> r2 blocked until three returns.
- Assert rst_n low mid-stream with sched_v=1 -> all outputs reset, index_f all 7. After release, first grant goes to the lowest active requestor.
